furf_writer: RTL

FURF_WRITER -- requirements
Module: furf_writer

---
 rtl/furf_writer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/furf_writer.sv
// FUVRF byte-stream writer: collects a header address byte plus BYTES data bytes
// from the configuration bus and issues a single-cycle port-b write.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a header (address) byte
// LOAD    | shifting data bytes, MSB first, for a valid address
// DISCARD | swallowing the data bytes that follow a bad address
// WRITE   | one-cycle write pulse on port b
module furf_writer #(
  parameter int M                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int FUVRF_SIZE         = 4,
  parameter int PERSONAL_CONFIG_ID = 1,
  parameter int AW                 = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1,
  parameter int WORD_W             = M * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tracing,
  input  logic [7:0]        configId,
  input  logic [7:0]        configData,
  output logic [AW-1:0]     mem_address_b,
  output logic              mem_write_enable_b,
  output logic [WORD_W-1:0] mem_in_b,
  output logic              busy,
  output logic              addr_err,
  output logic              abort_err,
  output logic [7:0]        write_count
);

  localparam int BYTES = WORD_W / 8;
  localparam int CW    = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DISCARD, WRITE} state_t;

  state_t              state;
  logic [CW-1:0]       byte_cnt;
  logic [WORD_W-1:0]   shift_q;
  logic [AW-1:0]       addr_q;
  logic                strobe;
  logic                addr_ok;
  logic [WORD_W+7:0]   shift_wide;
  logic [WORD_W-1:0]   shift_next;

  assign strobe     = (configId == 8'(PERSONAL_CONFIG_ID)) && !tracing;
  assign addr_ok    = 32'(configData) < 32'(FUVRF_SIZE);
  // Widened concat keeps the shift legal even when the word is a single byte.
  assign shift_wide = {shift_q, configData};
  assign shift_next = shift_wide[WORD_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      shift_q            <= '0;
      addr_q             <= '0;
      mem_address_b      <= '0;
      mem_write_enable_b <= 1'b0;
      mem_in_b           <= '0;
      busy               <= 1'b0;
      addr_err           <= 1'b0;
      abort_err          <= 1'b0;
      write_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (addr_ok) begin
              addr_q <= configData[AW-1:0];
              state  <= LOAD;
            end else begin
              addr_err <= 1'b1;
              state    <= DISCARD;
            end
          end
        end
        LOAD: begin
          if (tracing) begin
            abort_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (strobe) begin
            shift_q  <= shift_next;
            byte_cnt <= byte_cnt + 1'b1;
            // Outputs load on the same edge so the pulse lands one cycle after the last byte.
            if (byte_cnt == LAST_IDX) begin
              mem_in_b           <= shift_next;
              mem_address_b      <= addr_q;
              mem_write_enable_b <= 1'b1;
              state              <= WRITE;
            end
          end
        end
        DISCARD: begin
          if (tracing) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (strobe) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_IDX) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          mem_write_enable_b <= 1'b0;
          write_count        <= write_count + 8'd1;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
